// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit between the ID and EX stages.
// It produces per-operand EX forwarding selects and sequences load-use stalls.
// It also provides an interlock-only mode and keeps a saturating count of
// stalled cycles.
module fwd_hazard_unit #(
  parameter int ADDR_W     = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_FWD    = 2,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = $clog2(NUM_FWD + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       fwd_en_i,
  input  logic                       clr_i,
  input  logic                       id_valid_i,
  input  logic [NUM_SRC*ADDR_W-1:0]  id_src_addr_i,
  input  logic [NUM_SRC-1:0]         id_src_valid_i,
  input  logic [ADDR_W-1:0]          idex_rd_i,
  input  logic                       idex_regwrite_i,
  input  logic                       idex_memread_i,
  input  logic [NUM_SRC*ADDR_W-1:0]  ex_src_addr_i,
  input  logic [NUM_FWD*ADDR_W-1:0]  fwd_rd_i,
  input  logic [NUM_FWD-1:0]         fwd_regwrite_i,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o,
  output logic                       stall_o,
  output logic                       flush_o,
  output logic [CNT_W-1:0]           stall_cnt_o
);

  typedef enum logic {
    S_IDLE,
    S_LDSTALL
  } state_t;

  // Extra bubbles beyond the first one. The first bubble is taken in IDLE.
  localparam bit         MULTI_STALL = (LOAD_STALL > 1);
  localparam logic [3:0] BUB_INIT    = MULTI_STALL ? 4'(LOAD_STALL - 2) : 4'd0;

  state_t             state_q, state_d;
  logic [3:0]         bub_q, bub_d;
  logic               stall_raw;
  logic               load_use_hit;
  logic               interlock_hit;
  logic               idex_writes;
  logic [ADDR_W-1:0]  id_addr;
  logic [ADDR_W-1:0]  ex_addr;
  logic [ADDR_W-1:0]  stage_rd;

  // Forwarding selects. The loop scans from the oldest stage to the youngest,
  // so the youngest matching stage is written last and wins.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first. Otherwise a path that skips the assignment infers a latch.
    fwd_sel_o = '0;
    ex_addr   = '0;
    stage_rd  = '0;
    if (fwd_en_i) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        ex_addr = ex_src_addr_i[j*ADDR_W +: ADDR_W];
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
          stage_rd = fwd_rd_i[k*ADDR_W +: ADDR_W];
          if (fwd_regwrite_i[k] && (stage_rd != '0) && (stage_rd == ex_addr))
            fwd_sel_o[j*SEL_W +: SEL_W] = SEL_W'(k + 1);
        end
      end
    end
  end

  // Hazard detection on the ID-stage operands: load-use and interlock.
  always_comb begin
    load_use_hit  = 1'b0;
    interlock_hit = 1'b0;
    id_addr       = '0;
    idex_writes   = idex_regwrite_i && (idex_rd_i != '0);
    for (int j = 0; j < NUM_SRC; j++) begin
      id_addr = id_src_addr_i[j*ADDR_W +: ADDR_W];
      if (id_src_valid_i[j]) begin
        if (idex_writes && (id_addr == idex_rd_i)) begin
          interlock_hit = 1'b1;
          if (idex_memread_i)
            load_use_hit = 1'b1;
        end
        for (int k = 0; k < NUM_FWD; k++) begin
          if (fwd_regwrite_i[k] && (fwd_rd_i[k*ADDR_W +: ADDR_W] != '0) &&
              (fwd_rd_i[k*ADDR_W +: ADDR_W] == id_addr))
            interlock_hit = 1'b1;
        end
      end
    end
    load_use_hit  = load_use_hit && id_valid_i;
    interlock_hit = interlock_hit && id_valid_i && !fwd_en_i;
  end

  // Stall FSM next-state and stall decode. Once LDSTALL is entered it runs
  // to completion, whatever the mode input does.
  always_comb begin
    state_d   = state_q;
    bub_d     = bub_q;
    stall_raw = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fwd_en_i) begin
          if (load_use_hit) begin
            stall_raw = 1'b1;
            if (MULTI_STALL) begin
              state_d = S_LDSTALL;
              bub_d   = BUB_INIT;
            end
          end
        end else begin
          stall_raw = interlock_hit;
        end
      end
      S_LDSTALL: begin
        stall_raw = 1'b1;
        if (bub_q == 4'd0)
          state_d = S_IDLE;
        else
          bub_d = bub_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall and flush are held low for the whole time reset is asserted.
  assign stall_o = rst_i && stall_raw;
  assign flush_o = stall_o;

  // FSM state and bubble counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: clocked state uses non-blocking assignments only. Every register
    // then samples the values from before the edge, whatever order the
    // statements are in.
    if (!rst_i) begin
      state_q <= S_IDLE;
      bub_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  // Saturating count of stalled cycles. Clear beats increment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      stall_cnt_o <= '0;
    else if (clr_i)
      stall_cnt_o <= '0;
    else if (stall_raw && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + 1'b1;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit.
// It runs directed scenarios and then randomized traffic. Each cycle is
// compared against a behavioural model that tracks only the remaining
// bubble count and the stalled-cycle total.
module tb_fwd_hazard_unit;

  localparam int ADDR_W     = 5;
  localparam int NUM_SRC    = 2;
  localparam int NUM_FWD    = 2;
  localparam int LOAD_STALL = 3;
  localparam int CNT_W      = 4;
  localparam int SEL_W      = $clog2(NUM_FWD + 1);
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  logic                      fwd_en_i;
  logic                      clr_i;
  logic                      id_valid_i;
  logic [NUM_SRC*ADDR_W-1:0] id_src_addr_i;
  logic [NUM_SRC-1:0]        id_src_valid_i;
  logic [ADDR_W-1:0]         idex_rd_i;
  logic                      idex_regwrite_i;
  logic                      idex_memread_i;
  logic [NUM_SRC*ADDR_W-1:0] ex_src_addr_i;
  logic [NUM_FWD*ADDR_W-1:0] fwd_rd_i;
  logic [NUM_FWD-1:0]        fwd_regwrite_i;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o;
  logic                      stall_o;
  logic                      flush_o;
  logic [CNT_W-1:0]          stall_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: bubbles still owed after the current cycle, and the count.
  int model_rem = 0;
  int model_cnt = 0;

  fwd_hazard_unit #(
    .ADDR_W    (ADDR_W),
    .NUM_SRC   (NUM_SRC),
    .NUM_FWD   (NUM_FWD),
    .LOAD_STALL(LOAD_STALL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .fwd_en_i       (fwd_en_i),
    .clr_i          (clr_i),
    .id_valid_i     (id_valid_i),
    .id_src_addr_i  (id_src_addr_i),
    .id_src_valid_i (id_src_valid_i),
    .idex_rd_i      (idex_rd_i),
    .idex_regwrite_i(idex_regwrite_i),
    .idex_memread_i (idex_memread_i),
    .ex_src_addr_i  (ex_src_addr_i),
    .fwd_rd_i       (fwd_rd_i),
    .fwd_regwrite_i (fwd_regwrite_i),
    .fwd_sel_o      (fwd_sel_o),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // A writer counts as a producer of addr only when it writes a nonzero register.
  function automatic bit writes_to(input logic [ADDR_W-1:0] addr,
                                   input logic [ADDR_W-1:0] rd, input logic we);
    return we && (rd != '0) && (rd == addr);
  endfunction

  function automatic bit model_load_use();
    bit hit = 0;
    for (int j = 0; j < NUM_SRC; j++)
      if (id_src_valid_i[j] &&
          writes_to(id_src_addr_i[j*ADDR_W +: ADDR_W], idex_rd_i, idex_regwrite_i))
        hit = 1;
    return hit && id_valid_i && idex_memread_i;
  endfunction

  function automatic bit model_interlock();
    bit hit = 0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (id_src_valid_i[j]) begin
        if (writes_to(id_src_addr_i[j*ADDR_W +: ADDR_W], idex_rd_i, idex_regwrite_i))
          hit = 1;
        for (int k = 0; k < NUM_FWD; k++)
          if (writes_to(id_src_addr_i[j*ADDR_W +: ADDR_W],
                        fwd_rd_i[k*ADDR_W +: ADDR_W], fwd_regwrite_i[k]))
            hit = 1;
      end
    end
    return hit && id_valid_i && !fwd_en_i;
  endfunction

  // Expected select: one more than the index of the youngest producing stage.
  function automatic int model_sel(input int j);
    if (!fwd_en_i) return 0;
    for (int k = 0; k < NUM_FWD; k++)
      if (writes_to(ex_src_addr_i[j*ADDR_W +: ADDR_W],
                    fwd_rd_i[k*ADDR_W +: ADDR_W], fwd_regwrite_i[k]))
        return k + 1;
    return 0;
  endfunction

  // One clock cycle: compare outputs at the falling edge, advance the model at
  // the rising edge, and return 1 ns later so the caller can drive new inputs.
  task automatic step();
    bit exp_stall;
    int nrem;
    @(negedge clk_i);
    if (!rst_i) begin
      exp_stall = 0;
      nrem      = 0;
    end else if (model_rem > 0) begin
      exp_stall = 1;
      nrem      = model_rem - 1;
    end else if (fwd_en_i) begin
      exp_stall = model_load_use();
      nrem      = exp_stall ? LOAD_STALL - 1 : 0;
    end else begin
      exp_stall = model_interlock();
      nrem      = 0;
    end
    check("stall", 32'(stall_o), 32'(exp_stall));
    check("flush", 32'(flush_o), 32'(exp_stall));
    check("stall_cnt", 32'(stall_cnt_o), 32'(model_cnt));
    for (int j = 0; j < NUM_SRC; j++)
      check($sformatf("sel%0d", j), 32'(fwd_sel_o[j*SEL_W +: SEL_W]), 32'(model_sel(j)));
    @(posedge clk_i);
    if (!rst_i) begin
      model_rem = 0;
      model_cnt = 0;
    end else begin
      model_rem = nrem;
      if (clr_i)
        model_cnt = 0;
      else if (exp_stall && model_cnt < CNT_MAX)
        model_cnt++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    fwd_en_i        = 1'b1;
    clr_i           = 1'b0;
    id_valid_i      = 1'b0;
    id_src_addr_i   = '0;
    id_src_valid_i  = '0;
    idex_rd_i       = '0;
    idex_regwrite_i = 1'b0;
    idex_memread_i  = 1'b0;
    ex_src_addr_i   = '0;
    fwd_rd_i        = '0;
    fwd_regwrite_i  = '0;
  endtask

  // Drive reset low in the middle of a cycle. The model mirrors its immediate effect.
  task automatic assert_reset();
    rst_i     = 1'b0;
    model_rem = 0;
    model_cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    // Reset values.
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_cnt", 32'(stall_cnt_o), 32'd0);
    step();
    rst_i = 1'b1;
    step();

    // Forwarding priority between the two stages.
    fwd_rd_i       = {5'd5, 5'd5};
    fwd_regwrite_i = 2'b11;
    ex_src_addr_i  = {5'd0, 5'd5};
    #1 check("prio_both", 32'(fwd_sel_o[0 +: SEL_W]), 32'd1);
    fwd_regwrite_i = 2'b10;
    #1 check("prio_old", 32'(fwd_sel_o[0 +: SEL_W]), 32'd2);
    fwd_rd_i       = '0;
    fwd_regwrite_i = 2'b11;
    #1 check("prio_rd0", 32'(fwd_sel_o[0 +: SEL_W]), 32'd0);
    step();

    // Load-use hazard with LOAD_STALL=3. The hit is withdrawn after the
    // first cycle and the sequence still runs to completion.
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    id_valid_i      = 1'b1;
    id_src_addr_i   = {5'd8, 5'd0};
    id_src_valid_i  = 2'b10;
    idex_rd_i       = 5'd8;
    idex_regwrite_i = 1'b1;
    idex_memread_i  = 1'b1;
    step();
    idex_memread_i = 1'b0;
    step();
    step();
    step();
    check("lu_cnt3", 32'(stall_cnt_o), 32'd3);
    check("lu_done", 32'(stall_o), 32'd0);

    // Back-to-back hazard: the hit is held across the return to IDLE.
    idex_memread_i = 1'b1;
    repeat (7) step();
    idle_inputs();
    step();

    // Interlock-only mode.
    fwd_en_i       = 1'b0;
    id_valid_i     = 1'b1;
    id_src_addr_i  = {5'd0, 5'd4};
    id_src_valid_i = 2'b01;
    fwd_rd_i       = {5'd4, 5'd0};
    fwd_regwrite_i = 2'b10;
    ex_src_addr_i  = {5'd4, 5'd4};
    #1 check("il_stall", 32'(stall_o), 32'd1);
    check("il_sel", 32'(fwd_sel_o), 32'd0);
    repeat (2) step();
    id_src_valid_i = 2'b00;
    #1 check("il_invalid", 32'(stall_o), 32'd0);
    step();
    id_src_valid_i = 2'b01;
    step();
    idle_inputs();
    step();

    // Reset in the 2nd cycle of a 3-cycle stall. The hit is still present
    // after release, so a fresh sequence starts.
    id_valid_i      = 1'b1;
    id_src_addr_i   = {5'd8, 5'd0};
    id_src_valid_i  = 2'b10;
    idex_rd_i       = 5'd8;
    idex_regwrite_i = 1'b1;
    idex_memread_i  = 1'b1;
    step();
    assert_reset();
    #1;
    check("rst_mid_stall", 32'(stall_o), 32'd0);
    check("rst_mid_cnt", 32'(stall_cnt_o), 32'd0);
    step();
    rst_i = 1'b1;
    step();
    idex_memread_i = 1'b0;
    step();
    step();
    step();
    check("rst_redo_cnt", 32'(stall_cnt_o), 32'd3);
    idle_inputs();

    // Counter saturation under a continuous interlock stall, then clear.
    fwd_en_i       = 1'b0;
    id_valid_i     = 1'b1;
    id_src_addr_i  = {5'd0, 5'd4};
    id_src_valid_i = 2'b01;
    fwd_rd_i       = {5'd4, 5'd0};
    fwd_regwrite_i = 2'b10;
    repeat (20) step();
    check("sat_hold", 32'(stall_cnt_o), 32'(CNT_MAX));
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    #1 check("clr_wins", 32'(stall_cnt_o), 32'd0);
    step();
    idle_inputs();
    step();

    // Randomized traffic with small address ranges, so matches are frequent.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0)
        assert_reset();
      else
        rst_i = 1'b1;
      fwd_en_i        = ($urandom_range(0, 3) != 0);
      clr_i           = ($urandom_range(0, 15) == 0);
      id_valid_i      = ($urandom_range(0, 3) != 0);
      id_src_addr_i   = {ADDR_W'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, 3))};
      id_src_valid_i  = NUM_SRC'($urandom);
      idex_rd_i       = ADDR_W'($urandom_range(0, 3));
      idex_regwrite_i = 1'($urandom);
      idex_memread_i  = 1'($urandom);
      ex_src_addr_i   = {ADDR_W'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, 3))};
      fwd_rd_i        = {ADDR_W'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, 3))};
      fwd_regwrite_i  = NUM_FWD'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
